// File: rtl/player_input_arbiter_pkg.sv
// player_input_arbiter_pkg
// Shared constants for the player input arbiter: the round state encoding,
// the gpio bit-field layout of one player controller and a helper that
// packs the CPU-visible result word.
package player_input_arbiter_pkg;

    // Round state encoding.
    localparam logic [1:0] DISARMED = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] LATCHED  = 2'd2;

    // Each controller occupies PLAYER_STRIDE gpio pins: GUESS_W guess bits
    // followed by the submit button.
    localparam int GUESS_W       = 8;
    localparam int PLAYER_STRIDE = 9;
    localparam int PID_W         = 2;
    localparam int RESULT_W      = 16;
    localparam int GPIN_W        = 36;
    localparam int SWITCH_W      = 10;

    // Result word as the CPU reads it: {6'b0, player_id, guess}.
    function automatic logic [RESULT_W-1:0] pack_result(input logic [PID_W-1:0]   pid,
                                                        input logic [GUESS_W-1:0] guess);
        return {{(RESULT_W-PID_W-GUESS_W){1'b0}}, pid, guess};
    endfunction

endpackage

// File: rtl/player_input_arbiter_if.sv
// player_input_arbiter_if
// Bus between the exmem I/O space (master) and the player input arbiter
// (slave).
//   arm             : master -> slave, one-cycle pulse opening a round
//   clear           : master -> slave, one-cycle pulse on a CPU read of the result
//   playerInput     : slave -> master, {6'b0, player_id, guess} of the winner
//   playerInputFlag : slave -> master, high while a result is pending
//   firstPlayerFlag : slave -> master, one-hot winner
//   switchInput     : slave -> master, synchronised board switches
interface player_input_arbiter_if;
    import player_input_arbiter_pkg::*;

    logic                arm;
    logic                clear;
    logic [RESULT_W-1:0] playerInput;
    logic                playerInputFlag;
    logic [3:0]          firstPlayerFlag;
    logic [SWITCH_W-1:0] switchInput;

    modport master (
        output arm,
        output clear,
        input  playerInput,
        input  playerInputFlag,
        input  firstPlayerFlag,
        input  switchInput
    );

    modport slave (
        input  arm,
        input  clear,
        output playerInput,
        output playerInputFlag,
        output firstPlayerFlag,
        output switchInput
    );

endinterface

// File: rtl/player_input_arbiter_debounce_edge.sv
// debounce_edge
// Debounces one already-synchronised button level and reports its rising
// edge.
//   clk, rst : clock, asynchronous active-high reset
//   din      : synchronised raw level
//   level    : debounced level; changes only after din has differed from it
//              for DEBOUNCE_CYCLES consecutive cycles
//   rise     : one-cycle pulse on each 0->1 transition of level
module debounce_edge #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [15:0] cnt_q, cnt_d;
    logic        level_q, level_d;
    logic        level_prev_q;

    // Any cycle where din agrees with the debounced level restarts the
    // count, so only an unbroken run of disagreement can flip the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (din == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/player_input_arbiter.sv
// player_input_arbiter
// Conditions the four player controllers (two-flop synchroniser, debounce,
// edge detect), picks the first player to submit once a round is armed and
// holds that player's guess until the CPU reads it.
//   clk            : system clock (CPU clock)
//   rst            : asynchronous active-high reset
//   gpins          : controller pins, player i: guess = [9i+7:9i], submit = [9i+8]
//   board_switches : raw board switches
//   io             : exmem-side bus (arm, clear, playerInput, playerInputFlag,
//                    firstPlayerFlag, switchInput)
module player_input_arbiter
    import player_input_arbiter_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          NUM_PLAYERS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIN_W-1:0]     gpins,
    input  logic [SWITCH_W-1:0]   board_switches,
    player_input_arbiter_if.slave io
);

    // Two-flop synchronisers for every controller pin and the switches.
    logic [GPIN_W-1:0]   gpins_meta_q, gpins_sync_q;
    logic [SWITCH_W-1:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpins_meta_q <= '0;
            gpins_sync_q <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
        end else begin
            gpins_meta_q <= gpins;
            gpins_sync_q <= gpins_meta_q;
            sw_meta_q    <= board_switches;
            sw_sync_q    <= sw_meta_q;
        end
    end

    assign io.switchInput = sw_sync_q;

    // Per-player debounce of submit; the guess is taken straight from the
    // synchronised pins in the cycle the press pulse fires.
    logic [NUM_PLAYERS-1:0] press;
    logic [NUM_PLAYERS-1:0] submit_level_unused;
    logic [GUESS_W-1:0]     guess [NUM_PLAYERS];

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        debounce_edge #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .din   (gpins_sync_q[p*PLAYER_STRIDE + GUESS_W]),
            .level (submit_level_unused[p]),
            .rise  (press[p])
        );
        assign guess[p] = gpins_sync_q[p*PLAYER_STRIDE +: GUESS_W];
    end

    // Fixed priority: scanning from the top down leaves the lowest pressing
    // index as the winner when presses coincide.
    logic                   win_valid;
    logic [PID_W-1:0]       win_id;
    logic [NUM_PLAYERS-1:0] win_onehot;

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (press[p]) begin
                win_valid = 1'b1;
                win_id    = p[PID_W-1:0];
            end
        end
        win_onehot = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << win_id;
    end

    // Round state machine and result registers.
    logic [1:0]             state_q, state_d;
    logic [RESULT_W-1:0]    result_q, result_d;
    logic                   flag_q, flag_d;
    logic [NUM_PLAYERS-1:0] first_q, first_d;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flag_d   = flag_q;
        first_d  = first_q;
        case (state_q)
            DISARMED: begin
                if (io.arm) state_d = ARMED;
            end
            ARMED: begin
                if (win_valid) begin
                    state_d  = LATCHED;
                    result_d = pack_result(win_id, guess[win_id]);
                    flag_d   = 1'b1;
                    first_d  = win_onehot;
                end
            end
            LATCHED: begin
                // Presses arriving here are edge pulses and are simply lost,
                // including one coinciding with clear.
                if (io.clear) begin
                    state_d  = ARMED;
                    result_d = '0;
                    flag_d   = 1'b0;
                    first_d  = '0;
                end
            end
            default: state_d = DISARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DISARMED;
            result_q <= '0;
            flag_q   <= 1'b0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            first_q  <= first_d;
        end
    end

    assign io.playerInput     = result_q;
    assign io.playerInputFlag = flag_q;
    assign io.firstPlayerFlag = first_q;

endmodule
